// File: rtl/rma_pipe_if.sv
// Operand/control bundle from the decoder into rma_pipe and the result/a0 view back out.
// master = decoder/control side, slave = the datapath.
interface rma_pipe_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic                     RegWrite;
  logic [DATA_WIDTH-1:0]    ImmOp;
  logic                     ALUsrc;
  logic [3:0]               ALUctrl;
  logic                     out_valid;
  logic [DATA_WIDTH-1:0]    ALUout;
  logic                     eq;
  logic [DATA_WIDTH-1:0]    a0;

  modport master (
    output in_valid, rs1, rs2, rd, RegWrite, ImmOp, ALUsrc, ALUctrl,
    input  in_ready, out_valid, ALUout, eq, a0
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, RegWrite, ImmOp, ALUsrc, ALUctrl,
    output in_ready, out_valid, ALUout, eq, a0
  );
endinterface

// File: rtl/rma_pipe.sv
// Register file + operand mux + ALU with a registered result (1-cycle latency) and write-back forwarding.
// Defining RMA_MUL_EN adds a DATA_WIDTH-cycle shift-add MUL that holds in_ready low while busy.
module rma_pipe #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input logic       clk,
  input logic       rst_n,
  rma_pipe_if.slave io
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;
  localparam int SW   = $clog2(DATA_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;

  logic [DATA_WIDTH-1:0]    regs [NREG];
  logic [DATA_WIDTH-1:0]    res_q;
  logic                     eq_q;
  logic                     pend_q;
  logic [ADDRESS_WIDTH-1:0] wb_rd_q;
  logic                     wb_we_q;

  logic                     fwd_ok;
  logic [DATA_WIDTH-1:0]    rs1_val;
  logic [DATA_WIDTH-1:0]    rs2_val;
  logic [DATA_WIDTH-1:0]    op1;
  logic [DATA_WIDTH-1:0]    op2;
  logic [DATA_WIDTH-1:0]    alu_res;
  logic [SW-1:0]            shamt;
  logic                     eq_c;
  logic                     accept;
  logic                     is_mul;
  logic                     load_alu;

  // The result register is the only pending write, so one compare per port covers forwarding.
  assign fwd_ok  = pend_q & wb_we_q & (wb_rd_q != '0);
  assign rs1_val = (fwd_ok && (wb_rd_q == io.rs1)) ? res_q : regs[io.rs1];
  assign rs2_val = (fwd_ok && (wb_rd_q == io.rs2)) ? res_q : regs[io.rs2];

  assign op1   = rs1_val;
  assign op2   = io.ALUsrc ? io.ImmOp : rs2_val;
  assign shamt = op2[SW-1:0];
  assign eq_c  = (op1 == op2);

  always_comb begin
    alu_res = '0;
    case (io.ALUctrl)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SLT:  alu_res = DATA_WIDTH'($signed(op1) < $signed(op2));
      OP_SLTU: alu_res = DATA_WIDTH'(op1 < op2);
      OP_SLL:  alu_res = op1 << shamt;
      OP_SRL:  alu_res = op1 >> shamt;
      OP_SRA:  alu_res = DATA_WIDTH'($unsigned($signed(op1) >>> shamt));
      default: alu_res = '0;
    endcase
  end

  assign accept   = io.in_valid & io.in_ready;
  assign load_alu = accept & ~is_mul;

`ifdef RMA_MUL_EN
  localparam logic [3:0]    OP_MUL   = 4'b1000;
  localparam logic [SW-1:0] CNT_LAST = SW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic                     mul_start;
  logic                     mul_done;
  logic [SW-1:0]            cnt_q;
  logic [DATA_WIDTH-1:0]    mcand_q;
  logic [DATA_WIDTH-1:0]    mplier_q;
  logic [DATA_WIDTH-1:0]    acc_q;
  logic [DATA_WIDTH-1:0]    acc_d;
  logic [ADDRESS_WIDTH-1:0] mul_rd_q;
  logic                     mul_we_q;
  logic                     mul_eq_q;

  assign is_mul      = (io.ALUctrl == OP_MUL);
  assign io.in_ready = rst_n & (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          mul_start = 1'b1;
          state_d   = MUL;
        end
      end
      MUL: begin
        if (cnt_q == CNT_LAST) begin
          mul_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One partial product per edge; the last step's sum goes straight into the result register.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mul_rd_q <= '0;
      mul_we_q <= 1'b0;
      mul_eq_q <= 1'b0;
    end else if (mul_start) begin
      cnt_q    <= '0;
      mcand_q  <= op1;
      mplier_q <= op2;
      acc_q    <= '0;
      mul_rd_q <= io.rd;
      mul_we_q <= io.RegWrite;
      mul_eq_q <= eq_c;
    end else if (state_q == MUL) begin
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
    end
  end
`else
  assign is_mul      = 1'b0;
  assign io.in_ready = rst_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      res_q   <= '0;
      eq_q    <= 1'b0;
      pend_q  <= 1'b0;
      wb_rd_q <= '0;
      wb_we_q <= 1'b0;
    end else begin
      if (fwd_ok) regs[wb_rd_q] <= res_q;
      pend_q <= 1'b0;
      if (load_alu) begin
        res_q   <= alu_res;
        eq_q    <= eq_c;
        wb_rd_q <= io.rd;
        wb_we_q <= io.RegWrite;
        pend_q  <= 1'b1;
      end
`ifdef RMA_MUL_EN
      if (mul_done) begin
        res_q   <= acc_d;
        eq_q    <= mul_eq_q;
        wb_rd_q <= mul_rd_q;
        wb_we_q <= mul_we_q;
        pend_q  <= 1'b1;
      end
`endif
    end
  end

  // pend_q is high exactly in the cycle a fresh result sits in res_q.
  assign io.out_valid = pend_q;
  assign io.ALUout    = res_q;
  assign io.eq        = eq_q;
  assign io.a0        = regs[A0_IDX];

endmodule

// File: tb/tb_rma_pipe.sv
// Directed bench for rma_pipe: ALU ops, forwarding, x0, eq, optional MUL stall and reset abort.
module tb_rma_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SLT  = 4'b0101;
  localparam logic [3:0] C_SLL  = 4'b0110;
  localparam logic [3:0] C_SRL  = 4'b0111;
  localparam logic [3:0] C_MUL  = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1001;
  localparam logic [3:0] C_SLTU = 4'b1010;

  rma_pipe_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

  rma_pipe #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] c, input int a, input int b, input int d,
                       input logic we, input logic src, input logic [31:0] imm);
    bus.ALUctrl  = c;
    bus.rs1      = 5'(a);
    bus.rs2      = 5'(b);
    bus.rd       = 5'(d);
    bus.RegWrite = we;
    bus.ALUsrc   = src;
    bus.ImmOp    = imm;
    bus.in_valid = 1'b1;
  endtask

  // Presents one op, waits (bounded) for in_ready, and returns just after the accepting edge.
  task automatic issue(input logic [3:0] c, input int a, input int b, input int d,
                       input logic we, input logic src, input logic [31:0] imm);
    int n;
    n = 0;
    drive(c, a, b, d, we, src, imm);
    while (bus.in_ready !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    step(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] exp);
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk(tag, bus.ALUout, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen_ov;

    bus.in_valid = 1'b0;
    bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
    bus.RegWrite = 1'b0; bus.ALUsrc = 1'b0; bus.ImmOp = '0; bus.ALUctrl = '0;
    rst_n = 1'b0;
    step(3);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_aluout", bus.ALUout, 32'd0);
    chk("rst_eq", 32'(bus.eq), 32'd0);
    chk("rst_a0", bus.a0, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    issue(C_ADD, 0, 0, 5, 1, 1, 32'd7);              expect_res("addi_x5", 32'd7);
    step(1);
    chk("ov_one_pulse", 32'(bus.out_valid), 32'd0);
    issue(C_ADD, 5, 0, 6, 1, 1, 32'd0);              expect_res("read_x5", 32'd7);

    issue(C_ADD, 0, 0, 10, 1, 1, 32'd3);             expect_res("x10_3", 32'd3);
    chk("a0_before", bus.a0, 32'd0);
    issue(C_ADD, 10, 10, 10, 1, 0, 32'd0);           expect_res("fwd_x10", 32'd6);
    chk("a0_first_wb", bus.a0, 32'd3);
    step(1);
    chk("a0_second_wb", bus.a0, 32'd6);

    issue(C_ADD, 0, 0, 1, 1, 1, 32'h8000_0000);      expect_res("x1_msb", 32'h8000_0000);
    issue(C_SRA, 1, 0, 2, 1, 1, 32'd4);              expect_res("sra", 32'hF800_0000);
    issue(C_SRL, 1, 0, 2, 1, 1, 32'd4);              expect_res("srl", 32'h0800_0000);
    issue(C_SLL, 2, 0, 2, 1, 1, 32'd4);              expect_res("sll_fwd", 32'h8000_0000);
    issue(C_ADD, 0, 0, 3, 1, 1, 32'd1);              expect_res("x3_1", 32'd1);
    issue(C_ADD, 0, 0, 4, 1, 1, 32'hFFFF_FFFF);      expect_res("x4_m1", 32'hFFFF_FFFF);
    issue(C_SLTU, 3, 4, 9, 1, 0, 32'd0);             expect_res("sltu", 32'd1);
    issue(C_SLT, 3, 4, 9, 1, 0, 32'd0);              expect_res("slt_pos_neg", 32'd0);
    issue(C_SLT, 4, 3, 9, 1, 0, 32'd0);              expect_res("slt_neg_pos", 32'd1);
    issue(C_SUB, 3, 4, 9, 1, 0, 32'd0);              expect_res("sub", 32'd2);
    issue(C_ADD, 4, 0, 9, 1, 1, 32'd2);              expect_res("add_wrap", 32'd1);
    issue(C_AND, 4, 0, 9, 1, 1, 32'h0000_0F0F);      expect_res("and", 32'h0000_0F0F);
    issue(C_OR, 3, 0, 9, 1, 1, 32'h0000_0010);       expect_res("or", 32'h0000_0011);
    issue(C_XOR, 4, 0, 9, 1, 1, 32'h0000_FFFF);      expect_res("xor", 32'hFFFF_0000);
    issue(C_SLL, 3, 0, 9, 1, 1, 32'd36);             expect_res("sll_shamt_mask", 32'd16);

    issue(C_ADD, 0, 0, 0, 1, 1, 32'h55);             expect_res("x0_write", 32'h55);
    issue(C_ADD, 0, 0, 7, 1, 1, 32'd0);              expect_res("x0_no_fwd", 32'd0);
    step(1);
    issue(C_OR, 0, 0, 7, 1, 0, 32'd0);               expect_res("x0_stored", 32'd0);
    chk("eq_x0_x0", 32'(bus.eq), 32'd1);

    issue(C_ADD, 0, 0, 8, 1, 1, 32'd9);              expect_res("x8_9", 32'd9);
    issue(C_XOR, 8, 0, 9, 1, 1, 32'd9);              expect_res("xor_eq", 32'd0);
    chk("eq_9_9", 32'(bus.eq), 32'd1);
    issue(C_XOR, 8, 0, 9, 1, 1, 32'd8);              expect_res("xor_ne", 32'd1);
    chk("eq_9_8", 32'(bus.eq), 32'd0);
    issue(4'b1011, 8, 0, 9, 1, 1, 32'd9);            expect_res("unused_op", 32'd0);
    chk("eq_unused", 32'(bus.eq), 32'd1);
    issue(4'b1111, 8, 0, 9, 1, 1, 32'd5);            expect_res("unused_op2", 32'd0);
    chk("eq_unused2", 32'(bus.eq), 32'd0);

`ifdef RMA_MUL_EN
    issue(C_ADD, 0, 0, 11, 1, 1, 32'h0001_0000);     expect_res("x11", 32'h0001_0000);
    issue(C_ADD, 0, 0, 12, 1, 1, 32'h0001_0001);     expect_res("x12", 32'h0001_0001);
    issue(C_MUL, 11, 12, 13, 1, 0, 32'd0);
    chk("mul_busy", 32'(bus.in_ready), 32'd0);
    chk("mul_no_ov0", 32'(bus.out_valid), 32'd0);
    drive(C_ADD, 13, 0, 14, 1, 1, 32'd1);
    n = 0;
    seen_ov = 1'b0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      step(1);
      n++;
      if (bus.in_ready !== 1'b1 && bus.out_valid === 1'b1) seen_ov = 1'b1;
    end
    chk("mul_stall_cycles", 32'(n), 32'd32);
    chk("mul_early_ov", 32'(seen_ov), 32'd0);
    expect_res("mul_wrap", 32'h0001_0000);
    step(1);
    bus.in_valid = 1'b0;
    expect_res("held_op_fwd", 32'h0001_0001);

    issue(C_MUL, 11, 12, 10, 1, 0, 32'd0);
    step(9);
`else
    issue(C_MUL, 8, 0, 9, 1, 1, 32'd5);              expect_res("mul_unbuilt", 32'd0);
    chk("a0_keep", bus.a0, 32'd6);
    issue(C_ADD, 0, 0, 10, 1, 1, 32'h77);            expect_res("x10_77", 32'h77);
`endif
    rst_n = 1'b0;
    step(1);
    chk("rst2_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst2_rel_in_ready", 32'(bus.in_ready), 32'd1);
    seen_ov = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.out_valid === 1'b1) seen_ov = 1'b1;
    end
    chk("rst2_no_ov", 32'(seen_ov), 32'd0);
    chk("rst2_a0", bus.a0, 32'd0);
    chk("rst2_aluout", bus.ALUout, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
